// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V pipeline types and widths for the fetch stage
package riscv_pkg;

   localparam int DATA_WIDTH  = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {FS_REQ, FS_WAIT, FS_HOLD} fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// rtl/fetch_perf_counters.sv - fetch-stage event counters, present only with FETCH_CTRL_PERF_EN
module fetch_perf_counters (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetched_evt,
   input  logic        stall_evt,
   input  logic        squash_evt,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_squashed
);

   // Counters wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched  <= '0;
         perf_stall    <= '0;
         perf_squashed <= '0;
      end else begin
         if (fetched_evt) perf_fetched  <= perf_fetched + 32'd1;
         if (stall_evt)   perf_stall    <= perf_stall + 32'd1;
         if (squash_evt)  perf_squashed <= perf_squashed + 32'd1;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC owner and single-outstanding imem fetch sequencer feeding decode
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
   parameter int                    DATA_WIDTH = riscv_pkg::DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic [DATA_WIDTH-1:0] pc,
   output logic                  valid,
   input  logic                  ready,
   output logic [31:0]           perf_fetched,
   output logic [31:0]           perf_stall,
   output logic [31:0]           perf_squashed
);
   import riscv_pkg::*;

   fetch_state_t          state_q, state_d;
   logic                  kill_q, kill_d;
   logic                  capture;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] instr_q;
   logic [DATA_WIDTH-1:0] pc_out_q;
   logic [DATA_WIDTH-1:0] redirect_target;
   logic                  unused_redirect_low;

   assign redirect_target     = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
   assign unused_redirect_low = ^redirect_pc[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FS_REQ;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
      end
   end

   // kill marks an accepted request whose response belongs to the wrong path.
   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      capture = 1'b0;
      case (state_q)
         FS_REQ: begin
            if (imem_req_ready) begin
               state_d = FS_WAIT;
               kill_d  = redirect_valid;
            end
         end
         FS_WAIT: begin
            if (imem_rsp_valid) begin
               state_d = FS_REQ;
               kill_d  = 1'b0;
               if (!redirect_valid && !kill_q) begin
                  state_d = FS_HOLD;
                  capture = 1'b1;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         FS_HOLD: begin
            if (redirect_valid || ready) state_d = FS_REQ;
         end
         default: state_d = FS_REQ;
      endcase
   end

   always_comb begin
      imem_req_valid = (state_q == FS_REQ);
      imem_addr      = pc_q;
      valid          = (state_q == FS_HOLD);
      instruction    = instr_q;
      pc             = pc_out_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         pc_out_q <= '0;
      end else begin
         if (redirect_valid) pc_q <= redirect_target;
         else if (capture)   pc_q <= pc_q + DATA_WIDTH'(INSTR_BYTES);
         if (capture) begin
            instr_q  <= imem_rsp_data;
            pc_out_q <= pc_q;
         end
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   logic fetched_evt, stall_evt, squash_evt;

   assign fetched_evt = valid && ready;
   assign stall_evt   = valid && !ready;
   assign squash_evt  = ((state_q == FS_WAIT) && imem_rsp_valid && kill_q) ||
                        ((state_q == FS_HOLD) && redirect_valid);

   fetch_perf_counters u_perf (
      .clk           (clk),
      .rst           (rst),
      .fetched_evt   (fetched_evt),
      .stall_evt     (stall_evt),
      .squash_evt    (squash_evt),
      .perf_fetched  (perf_fetched),
      .perf_stall    (perf_stall),
      .perf_squashed (perf_squashed)
   );
`else
   assign perf_fetched  = 32'd0;
   assign perf_stall    = 32'd0;
   assign perf_squashed = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl with a latency-programmable imem model
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        valid;
   logic        ready;
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
   logic [31:0] perf_squashed;

   int errors = 0;
   int checks = 0;

   fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0100)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instruction    (instruction),
      .pc             (pc),
      .valid          (valid),
      .ready          (ready),
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall),
      .perf_squashed  (perf_squashed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: one outstanding read, data answers mem_lat cycles after the accept cycle.
   logic        mem_pend;
   int          mem_cnt;
   int          mem_lat;
   logic [31:0] mem_addr_q;
   logic        force_rsp;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mem_pend <= 1'b0;
      end else if (imem_req_valid && imem_req_ready) begin
         mem_pend   <= 1'b1;
         mem_cnt    <= mem_lat;
         mem_addr_q <= imem_addr;
      end else if (mem_pend && mem_cnt == 0) begin
         mem_pend <= 1'b0;
      end else if (mem_pend) begin
         mem_cnt <= mem_cnt - 1;
      end
   end

   assign imem_rsp_valid = (mem_pend && mem_cnt == 0) || force_rsp;
   assign imem_rsp_data  = force_rsp ? 32'hDEAD_BEEF : mem_word(mem_addr_q);

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] a;
      rst = 1'b1; ready = 1'b1; imem_req_ready = 1'b1; mem_lat = 0; force_rsp = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      repeat (2) cycle();
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("rst_addr", imem_addr, 32'h100);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_instr", instruction, 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_perf_fetched", perf_fetched, 32'd0);
      chk("rst_perf_stall", perf_stall, 32'd0);
      chk("rst_perf_squashed", perf_squashed, 32'd0);
      rst = 1'b0;

      // Zero-wait stream: one instruction every third cycle.
      for (int i = 0; i < 3; i++) begin
         a = 32'h100 + 32'(4 * i);
         chk("seq_req_valid", {31'd0, imem_req_valid}, 32'd1);
         chk("seq_addr", imem_addr, a);
         cycle();
         chk("seq_wait_valid", {31'd0, valid}, 32'd0);
         cycle();
         chk("seq_hold_valid", {31'd0, valid}, 32'd1);
         chk("seq_pc", pc, a);
         chk("seq_instr", instruction, mem_word(a));
         cycle();
      end

      // Decode backpressure for 5 cycles in HOLD.
      ready = 1'b0;
      chk("stall_addr", imem_addr, 32'h10C);
      cycle();
      cycle();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {31'd0, valid}, 32'd1);
         chk("stall_pc", pc, 32'h10C);
         chk("stall_instr", instruction, mem_word(32'h10C));
         chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
         cycle();
      end
      chk("perf_stall_5", perf_stall, PERF ? 32'd5 : 32'd0);
      ready = 1'b1;
      cycle();
      chk("after_stall_valid", {31'd0, valid}, 32'd0);
      chk("after_stall_addr", imem_addr, 32'h110);
      chk("perf_fetched_4", perf_fetched, PERF ? 32'd4 : 32'd0);

      // Redirect while WAIT, response arrives two cycles later and is dropped.
      mem_lat = 2;
      cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      cycle();
      redirect_valid = 1'b0;
      chk("kill_wait_no_req", {31'd0, imem_req_valid}, 32'd0);
      cycle();
      chk("kill_rsp_cycle_valid", {31'd0, valid}, 32'd0);
      cycle();
      chk("kill_drop_valid", {31'd0, valid}, 32'd0);
      chk("kill_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("kill_addr", imem_addr, 32'h200);
      chk("perf_squashed_1", perf_squashed, PERF ? 32'd1 : 32'd0);
      mem_lat = 0;
      cycle();
      cycle();
      chk("redir_fetch_valid", {31'd0, valid}, 32'd1);
      chk("redir_fetch_pc", pc, 32'h200);
      chk("redir_fetch_instr", instruction, mem_word(32'h200));
      cycle();
      chk("redir_next_addr", imem_addr, 32'h204);

      // Redirect in the same cycle as the response, to the top word.
      cycle();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      chk("same_cycle_valid", {31'd0, valid}, 32'd0);
      chk("same_cycle_req", {31'd0, imem_req_valid}, 32'd1);
      chk("same_cycle_addr", imem_addr, 32'hFFFF_FFFC);
      cycle();
      cycle();
      chk("top_valid", {31'd0, valid}, 32'd1);
      chk("top_pc", pc, 32'hFFFF_FFFC);
      cycle();
      chk("wrap_req", {31'd0, imem_req_valid}, 32'd1);
      chk("wrap_addr", imem_addr, 32'h0);

      // Redirect flushes a held instruction.
      cycle();
      ready = 1'b0;
      cycle();
      chk("flush_hold_valid", {31'd0, valid}, 32'd1);
      chk("flush_hold_pc", pc, 32'h0);
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      cycle();
      redirect_valid = 1'b0; ready = 1'b1;
      chk("flush_valid", {31'd0, valid}, 32'd0);
      chk("flush_addr", imem_addr, 32'h40);
      chk("perf_squashed_2", perf_squashed, PERF ? 32'd2 : 32'd0);
      chk("perf_stall_6", perf_stall, PERF ? 32'd6 : 32'd0);
      chk("perf_fetched_6", perf_fetched, PERF ? 32'd6 : 32'd0);

      // Reset while WAIT; a stale response afterwards must be ignored.
      mem_lat = 3;
      cycle();
      chk("pre_rst_wait", {31'd0, imem_req_valid}, 32'd0);
      rst = 1'b1;
      cycle();
      rst = 1'b0; imem_req_ready = 1'b0;
      chk("post_rst_req", {31'd0, imem_req_valid}, 32'd1);
      chk("post_rst_addr", imem_addr, 32'h100);
      chk("post_rst_valid", {31'd0, valid}, 32'd0);
      chk("post_rst_perf", perf_fetched | perf_stall | perf_squashed, 32'd0);
      force_rsp = 1'b1;
      cycle();
      force_rsp = 1'b0;
      chk("stale_valid", {31'd0, valid}, 32'd0);
      chk("stale_addr", imem_addr, 32'h100);
      cycle();
      chk("stale_valid_late", {31'd0, valid}, 32'd0);
      imem_req_ready = 1'b1; mem_lat = 0;
      cycle();
      cycle();
      chk("post_rst_fetch_valid", {31'd0, valid}, 32'd1);
      chk("post_rst_fetch_pc", pc, 32'h100);
      chk("post_rst_fetch_instr", instruction, mem_word(32'h100));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
